// File: rtl/i2c_pkg.sv
// Shared constants for the I2C target: FSM state encoding, ACK/NACK levels and filter default.
package i2c_pkg;

  localparam int unsigned DEFAULT_FILTER_LEN = 3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef logic [3:0] state_t;

  localparam state_t StIdle     = 4'd0;
  localparam state_t StAddr     = 4'd1;
  localparam state_t StAddrAck  = 4'd2;
  localparam state_t StPtr      = 4'd3;
  localparam state_t StPtrAck   = 4'd4;
  localparam state_t StWdata    = 4'd5;
  localparam state_t StWdataAck = 4'd6;
  localparam state_t StRdata    = 4'd7;
  localparam state_t StRdataAck = 4'd8;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer, consecutive-sample glitch filter and edge detect for one I2C line.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, rise_q, fall_q;
  logic [CntW-1:0] cnt_q;

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        rise_q  <= sync2_q;
        fall_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target with an 8-bit auto-incrementing register-pointer interface to a local register file.
module i2c_target_regif
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h3C,
  parameter int unsigned FILTER_LEN  = DEFAULT_FILTER_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_pull_low,
  output logic [7:0] reg_ptr,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       nack_seen
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (scl_in),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (sda_in),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pull_q, pull_d;
  logic [7:0] ptr_q, ptr_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_req_q, rd_req_d;
  logic       rd_dly_q;
  logic       busy_q, busy_d;
  logic       nack_q, nack_d;
  logic       rw_q, rw_d;
  logic [7:0] rx_byte;

  assign rx_byte = {shift_q[6:0], sda_lvl};

  // Next-state logic: bus conditions first, then per-state bit handling on SCL edges.
  // In the ACK states cnt_q=8 means "ACK not yet driven", cnt_q=9 means "9th clock seen".
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    pull_d    = pull_q;
    ptr_d     = ptr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    rw_d      = rw_q;
    wr_en_d   = 1'b0;
    rd_req_d  = 1'b0;
    nack_d    = 1'b0;

    // Register file answers exactly two clocks after rd_req.
    if (rd_dly_q) shift_d = rd_data;

    if (start_det) begin
      state_d = StAddr;
      cnt_d   = 4'd0;
      shift_d = 8'd0;
      pull_d  = 1'b0;
    end else if (stop_det) begin
      state_d = StIdle;
      pull_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (state_q == StAddr) begin
                if (rx_byte[7:1] == TARGET_ADDR) begin
                  state_d = StAddrAck;
                  busy_d  = 1'b1;
                  rw_d    = rx_byte[0];
                end else begin
                  state_d = StIdle;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = rx_byte;
                state_d = StPtrAck;
              end else begin
                wr_data_d = rx_byte;
                wr_en_d   = 1'b1;
                state_d   = StWdataAck;
              end
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_rise) begin
            cnt_d    = 4'd9;
            rd_req_d = (state_q == StAddrAck) && rw_q;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              pull_d = 1'b1;
              if (state_q == StWdataAck) ptr_d = ptr_q + 8'd1;
            end else if (cnt_q == 4'd9) begin
              cnt_d = 4'd0;
              if ((state_q == StAddrAck) && rw_q) begin
                state_d = StRdata;
                pull_d  = ~shift_q[7];
              end else begin
                state_d = (state_q == StAddrAck) ? StPtr : StWdata;
                pull_d  = 1'b0;
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              pull_d  = 1'b0;
              state_d = StRdataAck;
            end else begin
              pull_d = ~shift_q[3'(4'd7 - cnt_q)];
            end
          end
        end
        StRdataAck: begin
          if (scl_rise) begin
            if (sda_lvl == I2C_ACK) begin
              ptr_d    = ptr_q + 8'd1;
              rd_req_d = 1'b1;
              state_d  = StRdata;
              cnt_d    = 4'd0;
            end else begin
              nack_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= 8'd0;
      cnt_q     <= 4'd0;
      pull_q    <= 1'b0;
      ptr_q     <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_data_q <= 8'd0;
      rd_req_q  <= 1'b0;
      rd_dly_q  <= 1'b0;
      busy_q    <= 1'b0;
      nack_q    <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      pull_q    <= pull_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rd_req_q  <= rd_req_d;
      rd_dly_q  <= rd_req_q;
      busy_q    <= busy_d;
      nack_q    <= nack_d;
      rw_q      <= rw_d;
    end
  end

  // Reset gates the SDA driver directly so the bus is released without waiting for a clock.
  assign sda_pull_low = pull_q & ~reset;
  assign reg_ptr      = ptr_q;
  assign wr_en        = wr_en_q;
  assign wr_data      = wr_data_q;
  assign rd_req       = rd_req_q;
  assign busy         = busy_q;
  assign nack_seen    = nack_q;

endmodule

// File: tb/tb_i2c_target_regif.sv
// Bench for i2c_target_regif: bit-banged I2C master, register-file model and transaction-level reference.
`timescale 1ns/1ps
module tb_i2c_target_regif;

  localparam logic [6:0] Addr = 7'h3C;
  localparam int Q = 8;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mem_init = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_pull_low;
  logic [7:0] reg_ptr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data = 8'd0;
  logic       busy;
  logic       nack_seen;

  assign sda_bus = sda_m & ~sda_pull_low;

  i2c_target_regif #(.TARGET_ADDR(Addr), .FILTER_LEN(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .scl_in       (scl_m),
    .sda_in       (sda_bus),
    .sda_pull_low (sda_pull_low),
    .reg_ptr      (reg_ptr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .busy         (busy),
    .nack_seen    (nack_seen)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int nack_cnt = 0;
  int spurious_cnt = 0;
  logic pull_prev = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] model_mem [256];
  logic [7:0] model_ptr;
  wr_t wr_log[$];
  bq_t tx;

  // Register file with a strict 2-clk read latency: data is only valid in the cycle the DUT samples.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
      rd_data <= 8'd0;
    end else begin
      if (wr_en) begin
        mem[reg_ptr] <= wr_data;
        wr_log.push_back(wr_t'({reg_ptr, wr_data}));
      end
      if (rd_req) begin
        rd_data <= mem[reg_ptr];
        rd_cnt  <= rd_cnt + 1;
      end else begin
        rd_data <= ~rd_data;
      end
      if (nack_seen) nack_cnt <= nack_cnt + 1;
    end
  end

  // SDA drive must never change while SCL is high.
  always @(posedge clk) begin
    pull_prev <= sda_pull_low;
    if (!reset && scl_m && (sda_pull_low !== pull_prev)) spurious_cnt <= spurious_cnt + 1;
  end

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b0; w(Q);
    scl_m = 1'b0; w(Q);
  endtask

  task automatic rep_start();
    sda_m = 1'b1; w(Q);
    scl_m = 1'b1; w(Q);
    sda_m = 1'b0; w(Q);
    scl_m = 1'b0; w(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; w(Q);
    scl_m = 1'b1; w(Q);
    sda_m = 1'b1; w(2 * Q);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    sda_m = b;
    if (glitch) begin
      w(Q / 2); scl_m = 1'b1; w(1); scl_m = 1'b0; w(Q - Q / 2 - 1);
    end else begin
      w(Q);
    end
    scl_m = 1'b1; w(2 * Q);
    scl_m = 1'b0; w(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; w(Q);
    scl_m = 1'b1; w(Q);
    b = sda_bus; w(Q);
    scl_m = 1'b0; w(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gbit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], i == gbit);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack_bit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack_bit, 1'b0);
  endtask

  // Write transaction after a (repeated) START; first byte is the pointer, the rest are data.
  task automatic do_write(input logic [6:0] a, input bq_t data, input int gbit);
    logic ack;
    wr_t exp[$];
    int base;
    base = wr_log.size();
    send_byte({a, 1'b0}, gbit, ack);
    checks++;
    if (ack !== ((a == Addr) ? 1'b0 : 1'b1)) begin
      errors++;
      $display("FAIL addr_ack a=%h: got %b expected %b", a, ack, (a == Addr) ? 1'b0 : 1'b1);
    end
    if (a == Addr) begin
      for (int i = 0; i < data.size(); i++) begin
        send_byte(data[i], -1, ack);
        checks++;
        if (ack !== 1'b0) begin
          errors++;
          $display("FAIL data_ack byte %0d: got %b expected 0", i, ack);
        end
        if (i == 0) begin
          model_ptr = data[i];
        end else begin
          exp.push_back(wr_t'({model_ptr, data[i]}));
          model_mem[model_ptr] = data[i];
          model_ptr = model_ptr + 8'd1;
        end
      end
    end
    w(2);
    checks++;
    if (wr_log.size() - base != exp.size()) begin
      errors++;
      $display("FAIL wr_count: got %0d expected %0d", wr_log.size() - base, exp.size());
    end
    for (int i = 0; i < exp.size() && base + i < wr_log.size(); i++) begin
      checks++;
      if (wr_log[base + i] !== exp[i]) begin
        errors++;
        $display("FAIL wr_entry %0d: got ptr %h data %h expected ptr %h data %h", i,
                 wr_log[base + i].addr, wr_log[base + i].data, exp[i].addr, exp[i].data);
      end
    end
  endtask

  // Read n bytes, ACKing all but the last.
  task automatic do_read(input int n);
    logic ack;
    logic [7:0] d;
    int r0, k0;
    r0 = rd_cnt;
    k0 = nack_cnt;
    send_byte({Addr, 1'b1}, -1, ack);
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL rd_addr_ack: got %b expected 0", ack);
    end
    for (int i = 0; i < n; i++) begin
      recv_byte(d, i == n - 1);
      checks++;
      if (d !== model_mem[model_ptr]) begin
        errors++;
        $display("FAIL rd_byte %0d @%h: got %h expected %h", i, model_ptr, d, model_mem[model_ptr]);
      end
      if (i != n - 1) model_ptr = model_ptr + 8'd1;
    end
    w(2);
    checks++;
    if (rd_cnt - r0 != n) begin
      errors++;
      $display("FAIL rd_req_count: got %0d expected %0d", rd_cnt - r0, n);
    end
    checks++;
    if (nack_cnt - k0 != 1) begin
      errors++;
      $display("FAIL nack_count: got %0d expected 1", nack_cnt - k0);
    end
  endtask

  task automatic test_reset();
    w(4);
    checks++;
    if ({sda_pull_low, reg_ptr, wr_en, wr_data, rd_req, busy, nack_seen} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {sda_pull_low, reg_ptr, wr_en, wr_data, rd_req, busy, nack_seen});
    end
    reset = 1'b0;
    mem_init = 1'b0;
    w(20);
    checks++;
    if ({sda_pull_low, reg_ptr, busy} !== 10'd0) begin
      errors++;
      $display("FAIL idle_outputs: got %h expected 0", {sda_pull_low, reg_ptr, busy});
    end
  endtask

  task automatic test_write_basic();
    tx = {8'h10, 8'hA5, 8'h5A};
    bus_start();
    do_write(Addr, tx, -1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_during: got %b expected 1", busy);
    end
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_stop: got %b expected 0", busy);
    end
    checks++;
    if (reg_ptr !== 8'h12) begin
      errors++;
      $display("FAIL write_ptr: got %h expected 12", reg_ptr);
    end
  endtask

  task automatic test_addr_mismatch();
    tx = {8'h55};
    bus_start();
    do_write(7'h3D, tx, -1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_busy: got %b expected 0", busy);
    end
    bus_stop();
    checks++;
    if (reg_ptr !== model_ptr) begin
      errors++;
      $display("FAIL mismatch_ptr: got %h expected %h", reg_ptr, model_ptr);
    end
  endtask

  task automatic test_read();
    tx = {8'h20, 8'h11, 8'h22};
    bus_start(); do_write(Addr, tx, -1); bus_stop();
    tx = {8'h20};
    bus_start(); do_write(Addr, tx, -1);
    rep_start(); do_read(2);
    bus_stop();
    checks++;
    if (reg_ptr !== 8'h21) begin
      errors++;
      $display("FAIL read_ptr: got %h expected 21", reg_ptr);
    end
  endtask

  task automatic test_wrap();
    tx = {8'hFF, 8'h01, 8'h02};
    bus_start(); do_write(Addr, tx, -1); bus_stop();
    checks++;
    if (reg_ptr !== 8'h01) begin
      errors++;
      $display("FAIL wrap_ptr: got %h expected 01", reg_ptr);
    end
  endtask

  task automatic test_glitch();
    tx = {8'h50, 8'hC3};
    bus_start(); do_write(Addr, tx, 3); bus_stop();
    checks++;
    if (reg_ptr !== 8'h51) begin
      errors++;
      $display("FAIL glitch_ptr: got %h expected 51", reg_ptr);
    end
  endtask

  task automatic test_reset_mid();
    logic ack, b;
    tx = {8'h40, 8'h00};
    bus_start(); do_write(Addr, tx, -1);
    tx = {8'h40};
    rep_start(); do_write(Addr, tx, -1);
    rep_start();
    send_byte({Addr, 1'b1}, -1, ack);
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_addr_ack: got %b expected 0", ack);
    end
    for (int i = 0; i < 3; i++) recv_bit(b);
    w(Q / 2);
    checks++;
    if (sda_pull_low !== 1'b1) begin
      errors++;
      $display("FAIL mid_pull_before: got %b expected 1", sda_pull_low);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (sda_pull_low !== 1'b0) begin
      errors++;
      $display("FAIL rst_pull_now: got %b expected 0", sda_pull_low);
    end
    @(posedge clk); #1;
    checks++;
    if ({sda_pull_low, reg_ptr, wr_en, rd_req, busy, nack_seen} !== 13'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {sda_pull_low, reg_ptr, wr_en, rd_req, busy, nack_seen});
    end
    @(negedge clk);
    reset = 1'b0;
    model_ptr = 8'd0;
    w(Q);
    bus_stop();
    tx = {8'h30, 8'h77};
    bus_start(); do_write(Addr, tx, -1); bus_stop();
    checks++;
    if (reg_ptr !== 8'h31) begin
      errors++;
      $display("FAIL post_rst_ptr: got %h expected 31", reg_ptr);
    end
  endtask

  task automatic test_random();
    int kind, nb;
    logic [6:0] bad;
    for (int it = 0; it < 8; it++) begin
      kind = $urandom_range(0, 2);
      tx.delete();
      tx.push_back(8'($urandom));
      nb = $urandom_range(0, 3);
      repeat (nb) tx.push_back(8'($urandom));
      bus_start();
      if (kind == 0) begin
        do_write(Addr, tx, -1);
      end else if (kind == 1) begin
        bad = 7'($urandom_range(0, 127));
        if (bad == Addr) bad = bad ^ 7'h01;
        do_write(bad, tx, -1);
      end else begin
        do_write(Addr, tx, -1);
        rep_start();
        do_read($urandom_range(1, 3));
      end
      bus_stop();
      checks++;
      if (reg_ptr !== model_ptr) begin
        errors++;
        $display("FAIL rand_ptr it%0d: got %h expected %h", it, reg_ptr, model_ptr);
      end
    end
  endtask

  task automatic test_sda_timing();
    checks++;
    if (spurious_cnt != 0) begin
      errors++;
      $display("FAIL sda_change_scl_high: got %0d expected 0", spurious_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i * 7 + 3);
    model_ptr = 8'd0;
    test_reset();
    test_write_basic();
    test_addr_mismatch();
    test_read();
    test_wrap();
    test_glitch();
    test_reset_mid();
    test_random();
    test_sda_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
